// File: rtl/int_mult_pool_arbiter.sv
// -----------------------------------------------------------------------------
// int_mult_pool_arbiter
//
// Owner-side arbiter for the shared 4x 54x54 integer multiplier pool. It
// decides whether the FFT or the NTT unit drives the pool operands, tracks
// every product in flight so its result valid goes back to the issuing unit,
// and drains the pool pipeline before ownership changes so results from two
// owners never interleave.
//
// Parameters
//   MULT_LATENCY  pool latency, operand issue -> result (legal 1..15)
//   HOLD_MAX      max owner cycles while the other unit waits (starve guard)
//
// Ports
//   clk            clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   req_fft        FFT pool request (level, held for the burst)
//   req_ntt        NTT pool request (level, held for the burst)
//   issue_fft      FFT presents valid operands this cycle
//   issue_ntt      NTT presents valid operands this cycle
//   gnt_fft        FFT owns the pool (registered)
//   gnt_ntt        NTT owns the pool (registered)
//   grant_to_fft   pool operand-mux select, 1 = FFT operands
//   res_valid_fft  pool result valid for FFT this cycle
//   res_valid_ntt  pool result valid for NTT this cycle
//   busy           arbiter not idle, or any product in flight
//   err_issue      sticky: an issue was seen without the matching grant
//
// Configuration macro
//   INTMULT_ARB_STARVE_GUARD_EN  when defined, an owner is preempted after
//   HOLD_MAX cycles of ownership while the other unit is requesting.
// -----------------------------------------------------------------------------
module int_mult_pool_arbiter #(
  parameter int MULT_LATENCY = 6,
  parameter int HOLD_MAX     = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_fft,
  input  logic req_ntt,
  input  logic issue_fft,
  input  logic issue_ntt,
  output logic gnt_fft,
  output logic gnt_ntt,
  output logic grant_to_fft,
  output logic res_valid_fft,
  output logic res_valid_ntt,
  output logic busy,
  output logic err_issue
);

  if (MULT_LATENCY < 1 || MULT_LATENCY > 15 || HOLD_MAX < 1) begin : g_bad_param
    $error("int_mult_pool_arbiter: MULT_LATENCY must be 1..15 and HOLD_MAX >= 1");
  end

  typedef enum logic [1:0] {IDLE, OWN_FFT, OWN_NTT, DRAIN} state_t;

  // The last pipeline stage is the result being delivered this cycle; only
  // the stages before it still hold products the drain has to wait for.
  localparam logic [MULT_LATENCY-1:0] LAST_STAGE = MULT_LATENCY'(1) << (MULT_LATENCY - 1);

  state_t state;
  logic   last_owner_fft;

  // In-flight tracker: one shift register per owner, so the final stage is
  // already the per-unit result valid and needs no decode after the flop.
  logic [MULT_LATENCY-1:0] pipe_fft;
  logic [MULT_LATENCY-1:0] pipe_ntt;

  logic issue_ok;
  logic issue_bad;
  logic pending;
  logic hold_expired;

  assign issue_ok  = (gnt_fft & issue_fft) | (gnt_ntt & issue_ntt);
  assign issue_bad = (issue_fft & ~gnt_fft) | (issue_ntt & ~gnt_ntt);
  assign pending   = |((pipe_fft | pipe_ntt) & ~LAST_STAGE);

  assign res_valid_fft = pipe_fft[MULT_LATENCY-1];
  assign res_valid_ntt = pipe_ntt[MULT_LATENCY-1];
  assign busy          = (state != IDLE) | (|pipe_fft) | (|pipe_ntt);

`ifdef INTMULT_ARB_STARVE_GUARD_EN
  localparam int HOLD_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);

  logic [HOLD_W-1:0] hold_cnt;
  logic              owning;
  logic              other_req;
  logic              own_exit;

  assign owning       = (state == OWN_FFT) | (state == OWN_NTT);
  assign other_req    = (state == OWN_FFT) ? req_ntt : req_fft;
  assign hold_expired = owning & other_req & (hold_cnt == HOLD_W'(HOLD_MAX - 1));
  assign own_exit     = ((state == OWN_FFT) & ~req_fft) |
                        ((state == OWN_NTT) & ~req_ntt) | hold_expired;

  // Counts owner cycles spent while the other unit waits; restarts whenever
  // the owner state is left so each new grant gets a full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (owning && !own_exit) begin
      if (other_req) hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign hold_expired = 1'b0;
`endif

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the values from before the clock edge, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      gnt_fft        <= 1'b0;
      gnt_ntt        <= 1'b0;
      grant_to_fft   <= 1'b0;
      last_owner_fft <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Round robin on contention: the unit that did not own last wins.
          if (req_fft && (!req_ntt || !last_owner_fft)) begin
            state          <= OWN_FFT;
            gnt_fft        <= 1'b1;
            grant_to_fft   <= 1'b1;
            last_owner_fft <= 1'b1;
          end else if (req_ntt) begin
            state          <= OWN_NTT;
            gnt_ntt        <= 1'b1;
            grant_to_fft   <= 1'b0;
            last_owner_fft <= 1'b0;
          end
        end
        OWN_FFT: begin
          if (!req_fft || hold_expired) begin
            state   <= DRAIN;
            gnt_fft <= 1'b0;
          end
        end
        OWN_NTT: begin
          if (!req_ntt || hold_expired) begin
            state   <= DRAIN;
            gnt_ntt <= 1'b0;
          end
        end
        DRAIN: begin
          // grant_to_fft is left alone so late results keep their owner.
          if (!pending) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the tracker is reset (not just its output) so products in flight
  // at reset are discarded and can never raise a result valid afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_fft  <= '0;
      pipe_ntt  <= '0;
      err_issue <= 1'b0;
    end else begin
      pipe_fft <= (pipe_fft << 1) | MULT_LATENCY'(issue_ok & grant_to_fft);
      pipe_ntt <= (pipe_ntt << 1) | MULT_LATENCY'(issue_ok & ~grant_to_fft);
      if (issue_bad) err_issue <= 1'b1;
    end
  end

endmodule

// File: tb/tb_int_mult_pool_arbiter.sv
// -----------------------------------------------------------------------------
// tb_int_mult_pool_arbiter
//
// Self-checking bench for int_mult_pool_arbiter (MULT_LATENCY=6, HOLD_MAX=8).
// Every accepted issue pushes its due cycle and owner into a scoreboard; a
// negedge monitor pops and compares both result valids each cycle.
// -----------------------------------------------------------------------------
module tb_int_mult_pool_arbiter;

  localparam int LAT  = 6;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_fft = 1'b0;
  logic req_ntt = 1'b0;
  logic issue_fft = 1'b0;
  logic issue_ntt = 1'b0;
  logic gnt_fft, gnt_ntt, grant_to_fft;
  logic res_valid_fft, res_valid_ntt, busy, err_issue;

  typedef struct {
    int   due;
    logic fft;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic exp_f, exp_n;

  int_mult_pool_arbiter #(.MULT_LATENCY(LAT), .HOLD_MAX(HOLD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_fft       (req_fft),
    .req_ntt       (req_ntt),
    .issue_fft     (issue_fft),
    .issue_ntt     (issue_ntt),
    .gnt_fft       (gnt_fft),
    .gnt_ntt       (gnt_ntt),
    .grant_to_fft  (grant_to_fft),
    .res_valid_fft (res_valid_fft),
    .res_valid_ntt (res_valid_ntt),
    .busy          (busy),
    .err_issue     (err_issue)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    exp_f = 1'b0;
    exp_n = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_f = sb[0].fft;
      exp_n = ~sb[0].fft;
      sb.delete(0);
    end
    check("res_valid_fft", res_valid_fft, exp_f);
    check("res_valid_ntt", res_valid_ntt, exp_n);
    check("gnt_mutex", gnt_fft & gnt_ntt, 1'b0);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Drive issue strobes; accepted ones go to the scoreboard.
  task automatic issue(input logic f, input logic n, input logic legal);
    issue_fft = f;
    issue_ntt = n;
    if (legal && f) sb.push_back('{due: cyc + LAT, fft: 1'b1});
    if (legal && n) sb.push_back('{due: cyc + LAT, fft: 1'b0});
  endtask

  // Leaves the bench in cycle 0 with reset just released.
  task automatic do_reset();
    rst_n = 1'b0;
    req_fft = 1'b0;
    req_ntt = 1'b0;
    issue(1'b0, 1'b0, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt_fft", gnt_fft, 1'b0);
    check("rst_gnt_ntt", gnt_ntt, 1'b0);
    check("rst_sel", grant_to_fft, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_issue, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    next();
    while (busy && n < budget) begin
      next();
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  initial begin
    // Single FFT burst: grant at 1, issues 1..3, results 7..9.
    do_reset();
    req_fft = 1'b1;
    next();
    check("s1_gnt_fft", gnt_fft, 1'b1);
    check("s1_sel", grant_to_fft, 1'b1);
    check("s1_gnt_ntt", gnt_ntt, 1'b0);
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b0, 1'b1);
      next();
    end
    issue(1'b0, 1'b0, 1'b0);
    req_fft = 1'b0;
    next();
    check("s1_drain_gnt", gnt_fft, 1'b0);
    check("s1_drain_sel_hold", grant_to_fft, 1'b1);
    check("s1_drain_busy", busy, 1'b1);
    wait_idle(40);

    // Round robin: FFT owned last, so contention goes to NTT.
    req_fft = 1'b1;
    req_ntt = 1'b1;
    next();
    check("rr_gnt_ntt", gnt_ntt, 1'b1);
    check("rr_gnt_fft", gnt_fft, 1'b0);
    check("rr_sel", grant_to_fft, 1'b0);
    req_fft = 1'b0;
    req_ntt = 1'b0;
    wait_idle(40);

    // Contention after reset, FFT last issue in the same cycle as req drop.
    do_reset();
    req_fft = 1'b1;
    req_ntt = 1'b1;
    next();
    check("s2_gnt_fft", gnt_fft, 1'b1);
    check("s2_gnt_ntt", gnt_ntt, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      issue(1'b1, 1'b0, 1'b1);
      if (i == 4) req_fft = 1'b0;
      next();
    end
    issue(1'b0, 1'b0, 1'b0);
    check("s2_drain_gnt_fft", gnt_fft, 1'b0);
    repeat (6) next();
    check("s2_c11_gnt_ntt", gnt_ntt, 1'b0);
    check("s2_c11_idle", busy, 1'b0);
    next();
    check("s2_c12_gnt_ntt", gnt_ntt, 1'b1);
    check("s2_c12_sel", grant_to_fft, 1'b0);
    issue(1'b0, 1'b1, 1'b1);
    next();
    issue(1'b0, 1'b1, 1'b1);
    req_ntt = 1'b0;
    next();
    issue(1'b0, 1'b0, 1'b0);
    wait_idle(40);

    // Issue without grant: sticky error, no pipeline entry.
    do_reset();
    issue(1'b0, 1'b1, 1'b0);
    next();
    issue(1'b0, 1'b0, 1'b0);
    check("s3_err_set", err_issue, 1'b1);
    repeat (8) next();
    check("s3_err_sticky", err_issue, 1'b1);
    check("s3_no_busy", busy, 1'b0);

    // Reset mid-burst with three products in flight.
    do_reset();
    req_fft = 1'b1;
    next();
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 1'b0, 1'b1);
      next();
    end
    issue(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("s4_async_gnt", gnt_fft, 1'b0);
    check("s4_async_busy", busy, 1'b0);
    check("s4_async_res", res_valid_fft, 1'b0);
    req_fft = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) next();
    check("s4_still_idle", busy, 1'b0);

    // FFT holds req while NTT waits.
    do_reset();
    req_fft = 1'b1;
    req_ntt = 1'b1;
    next();
    check("s5_gnt_fft_c1", gnt_fft, 1'b1);
    repeat (7) next();
    check("s5_gnt_fft_c8", gnt_fft, 1'b1);
    next();
`ifdef INTMULT_ARB_STARVE_GUARD_EN
    check("s5_forced_drain", gnt_fft, 1'b0);
    repeat (2) next();
    check("s5_gnt_ntt_c11", gnt_ntt, 1'b1);
    check("s5_sel_c11", grant_to_fft, 1'b0);
    repeat (10) next();
    check("s5_regrant_fft", gnt_fft, 1'b1);
    check("s5_regrant_ntt", gnt_ntt, 1'b0);
`else
    check("s5_hold_c9", gnt_fft, 1'b1);
    repeat (21) next();
    check("s5_hold_c30", gnt_fft, 1'b1);
    check("s5_ntt_waits", gnt_ntt, 1'b0);
`endif
    req_fft = 1'b0;
    req_ntt = 1'b0;
    wait_idle(40);

    repeat (10) next();
    check("sb_drained", sb.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
